div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Sequencer and arbiter that shares one iterative `divider` instance between NUM_REQ requesters (e.g. two issue lanes of the M-extension unit).
- Decodes RISC-V DIV/DIVU/REM/REMU into divider operands and signedness, and drives the divider's enable/data_valid protocol.
- Resolves divide-by-zero and signed-overflow locally, without using the divider.
- Returns a tagged result on a single shared response channel.

Parameters:
- XLEN, 32, operand/result width.
- NUM_REQ, 2, number of requesters.
- TAG_W, 4, width of the opaque request tag echoed with the result.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op  in  NUM_REQ*2  per-requester op: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  in  NUM_REQ*XLEN  dividends.
- req_b  in  NUM_REQ*XLEN  divisors.
- req_tag  in  NUM_REQ*TAG_W  tags.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  $clog2(NUM_REQ)  index of the originating requester.
- resp_tag  out  TAG_W  echoed tag.
- resp_data  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- div_a, div_b  out  XLEN  divider operands.
- div_signed_a, div_signed_b  out  1  both high for DIV/REM, low for DIVU/REMU.
- div_enable  out  1  divider enable.
- div_quotient, div_remainder  in  XLEN  divider results.
- div_data_valid  in  1  divider done.

Behaviour:

Reset and acceptance
- Reset values: all outputs 0, FSM IDLE, round-robin pointer 0, reuse entry invalid.
- Reset mid-operation:
  - div_enable drops asynchronously.
  - Any in-flight request is discarded with no response.
- Accept only in IDLE. req_ready[i] is asserted combinationally for the single winning requester. The winner is the first valid requester at or after the pointer, wrapping.
- A handshake occurs when req_valid[i] and req_ready[i] are both high. On handshake:
  - op, a, b, tag and id are latched.
  - pointer <= winner+1 mod NUM_REQ.

FSM states
- IDLE: wait for a handshake.
- From IDLE on accept:
  - b==0 → RESP. Quotient is all-ones; remainder is a. Applies to both signed and unsigned ops.
  - Signed op with a==1<<(XLEN-1) and b==all-ones → RESP. Quotient is a; remainder is 0.
  - Otherwise → BUSY.
- BUSY:
  - div_enable=1, with operands and signedness held stable from the latched request.
  - On div_data_valid=1, capture the required result and go to RESP.
  - div_enable is 0 in the capture cycle's successor.
- RESP:
  - resp_valid=1, with id, tag and data held stable until resp_ready.
  - On resp_valid && resp_ready → IDLE. resp_valid deasserts next cycle.
  - div_enable stays 0, guaranteeing at least one low cycle between divider operations.

Latency and throughput
- Bypass path: resp_valid rises 1 cycle after accept.
- Divider path: resp_valid rises 1 cycle after div_data_valid.
- One operation in flight at a time. No new accept while in BUSY or RESP.

Boundary conditions
- A requester dropping req_valid without a handshake is legal.
- A requester must not change op, a, b or tag while valid and not ready.
- Simultaneous valids follow strict round-robin order.
- resp_ready held low stalls indefinitely.

Optional Feature:
- DIV_SCHED_REUSE_EN defined:
  - Keep a one-entry cache of {a, b, signed, quotient, remainder} from the last divider completion.
  - An accepted request with matching a, b and signedness goes straight to RESP, with no div_enable. This covers a DIV followed by a REM of the same operands.
  - Bypass cases are never cached.
  - The entry is invalidated on reset.
- Undefined: no cache; every non-bypass request uses the divider.

Decomposition:
- Package div_sched_pkg holds:
  - op enum (DIV, DIVU, REM, REMU);
  - state enum (IDLE, BUSY, RESP);
  - helper functions is_signed_op and is_rem_op;
  - constant for the signed-overflow dividend.
- One sub-module, rr_arbiter: a NUM_REQ-wide round-robin grant with pointer update on accept.

Test Plan:
- Req0 DIVU a=15634654, b=21354 → resp_data=732, resp_id=0. REMU with the same operands → resp_data=3526.
- Req1 DIVU a=100, b=0 → resp_data=0xFFFFFFFF, 1 cycle after accept, div_enable never high. REMU → 100.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM → 0. Both via bypass.
- DIV a=-7, b=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. div_signed_a and div_signed_b high throughout BUSY.
- Both requesters valid continuously with 3 ops each → grants alternate 0,1,0,1,0,1. resp_ready low for 5 cycles in RESP → response fields stable, no req_ready asserted. Reset asserted during BUSY → div_enable and all outputs 0 immediately, no response.
- With DIV_SCHED_REUSE_EN: DIV 1000/7 then REM 1000/7 → REM resp_data=6, 1 cycle after accept, div_enable stays 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the divider sequencer/arbiter (div_sched).
package div_sched_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned MAX_XLEN     = 64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_signed_op(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Most negative signed dividend for a given width (the overflow case when divided by -1).
    function automatic logic [MAX_XLEN-1:0] signed_ovf_a(int unsigned xlen);
        return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
    endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Round-robin grant over N requesters; pointer moves past the winner on accept.
module rr_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_i,
    input  logic           accept_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o
);

    logic [IDW-1:0] ptr_q;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        logic           found;
        logic [IDW-1:0] j;
        found       = 1'b0;
        j           = '0;
        grant_idx_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IDW'((32'(ptr_q) + k) % N);
            if (!found && req_i[j]) begin
                found       = 1'b1;
                grant_idx_o = j;
            end
        end
        grant_o = found ? (N'(1) << grant_idx_o) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= (32'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + IDW'(1);
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one iterative divider between NUM_REQ requesters; zero-divisor and signed overflow
// are resolved locally. DIV_SCHED_REUSE_EN adds a one-entry cache of the last divider result.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int unsigned XLEN    = DEFAULT_XLEN,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ*XLEN-1:0]  req_a,
    input  logic [NUM_REQ*XLEN-1:0]  req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [XLEN-1:0]          resp_data,
    output logic [XLEN-1:0]          div_a,
    output logic [XLEN-1:0]          div_b,
    output logic                     div_signed_a,
    output logic                     div_signed_b,
    output logic                     div_enable,
    input  logic [XLEN-1:0]          div_quotient,
    input  logic [XLEN-1:0]          div_remainder,
    input  logic                     div_data_valid
);

    localparam logic [XLEN-1:0] OVF_A = XLEN'(signed_ovf_a(XLEN));

    state_e            state_q;
    logic              rem_q, resp_valid_q, div_enable_q, div_signed_q;
    logic [ID_W-1:0]   resp_id_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [XLEN-1:0]   resp_data_q, div_a_q, div_b_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;

    logic [1:0]       op_arr  [NUM_REQ];
    logic [XLEN-1:0]  a_arr   [NUM_REQ];
    logic [XLEN-1:0]  b_arr   [NUM_REQ];
    logic [TAG_W-1:0] tag_arr [NUM_REQ];

    div_op_e          sel_op;
    logic [XLEN-1:0]  sel_a, sel_b, bypass_data_d;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_signed, sel_rem, is_div0, is_ovf, hit, bypass_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]  = req_op[2*g +: 2];
        assign a_arr[g]   = req_a[g*XLEN +: XLEN];
        assign b_arr[g]   = req_b[g*XLEN +: XLEN];
        assign tag_arr[g] = req_tag[g*TAG_W +: TAG_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
        .clk         (clock),
        .rst_n       (reset_n),
        .req_i       (req_valid),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant & {NUM_REQ{reset_n && (state_q == ST_IDLE)}};
    assign accept    = |(req_valid & req_ready);

`ifdef DIV_SCHED_REUSE_EN
    logic            cache_vld_q, cache_signed_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

    // Remember operands and both results of the last divider completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld_q    <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
        end else if (state_q == ST_BUSY && div_data_valid) begin
            cache_vld_q    <= 1'b1;
            cache_signed_q <= div_signed_q;
            cache_a_q      <= div_a_q;
            cache_b_q      <= div_b_q;
            cache_quo_q    <= div_quotient;
            cache_rem_q    <= div_remainder;
        end
    end
`endif

    // Decode the winning request and decide whether the divider can be skipped.
    always_comb begin
        sel_op        = div_op_e'(op_arr[grant_idx]);
        sel_a         = a_arr[grant_idx];
        sel_b         = b_arr[grant_idx];
        sel_tag       = tag_arr[grant_idx];
        sel_signed    = is_signed_op(sel_op);
        sel_rem       = is_rem_op(sel_op);
        is_div0       = (sel_b == '0);
        is_ovf        = sel_signed && (sel_a == OVF_A) && (sel_b == '1);
        bypass_data_d = '0;
`ifdef DIV_SCHED_REUSE_EN
        hit = cache_vld_q && (cache_a_q == sel_a) && (cache_b_q == sel_b)
              && (cache_signed_q == sel_signed);
`else
        hit = 1'b0;
`endif
        bypass_d = is_div0 || is_ovf || hit;
        if (is_div0) begin
            bypass_data_d = sel_rem ? sel_a : '1;
        end else if (is_ovf) begin
            bypass_data_d = sel_rem ? '0 : sel_a;
        end else begin
`ifdef DIV_SCHED_REUSE_EN
            bypass_data_d = sel_rem ? cache_rem_q : cache_quo_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_signed_q <= 1'b0;
            div_enable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        resp_id_q    <= grant_idx;
                        resp_tag_q   <= sel_tag;
                        rem_q        <= sel_rem;
                        div_a_q      <= sel_a;
                        div_b_q      <= sel_b;
                        div_signed_q <= sel_signed;
                        if (bypass_d) begin
                            resp_data_q  <= bypass_data_d;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            div_enable_q <= 1'b1;
                            state_q      <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (div_data_valid) begin
                        resp_data_q  <= rem_q ? div_remainder : div_quotient;
                        resp_valid_q <= 1'b1;
                        div_enable_q <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_tag     = resp_tag_q;
    assign resp_data    = resp_data_q;
    assign div_a        = div_a_q;
    assign div_b        = div_b_q;
    assign div_signed_a = div_signed_q;
    assign div_signed_b = div_signed_q;
    assign div_enable   = div_enable_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a small multi-cycle divider model attached.
module tb_div_sched;
    import div_sched_pkg::*;

`ifdef DIV_SCHED_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [0:0]  resp_id;
    logic [3:0]  resp_tag;
    logic [31:0] resp_data, div_a, div_b, div_quotient, div_remainder;
    logic        div_signed_a, div_signed_b, div_enable;
    logic        div_data_valid = 1'b0;
    int          dcnt = 0;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    div_sched dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_tag(resp_tag), .resp_data(resp_data),
        .div_a(div_a), .div_b(div_b), .div_signed_a(div_signed_a), .div_signed_b(div_signed_b),
        .div_enable(div_enable), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_data_valid(div_data_valid)
    );

    // Divider model: result appears a few cycles after enable, as a one-cycle pulse.
    always @(posedge clock) begin
        if (!div_enable) begin
            dcnt           <= 0;
            div_data_valid <= 1'b0;
        end else if (div_data_valid) begin
            dcnt           <= 0;
            div_data_valid <= 1'b0;
        end else if (dcnt == 3) begin
            div_data_valid <= 1'b1;
            if (div_signed_a) begin
                div_quotient  <= $signed(div_a) / $signed(div_b);
                div_remainder <= $signed(div_a) % $signed(div_b);
            end else begin
                div_quotient  <= div_a / div_b;
                div_remainder <= div_a % div_b;
            end
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One request through handshake and response; exp_lat<=0 skips the latency check.
    task automatic run_op(input logic id, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp,
                          input int exp_lat, input logic exp_en, input string name);
        int   lat, w;
        logic en_seen, sig_bad, is_s;
        is_s = ~op[0];
        @(negedge clock);
        if (id) begin
            req_op[3:2] = op; req_a[63:32] = a; req_b[63:32] = b; req_tag[7:4] = tag;
        end else begin
            req_op[1:0] = op; req_a[31:0] = a; req_b[31:0] = b; req_tag[3:0] = tag;
        end
        req_valid[id] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[id] && w < 20) begin
            @(negedge clock); #1; w++;
        end
        chk({name, " ready"}, 32'(req_ready[id]), 32'd1);
        @(negedge clock);
        req_valid[id] = 1'b0;
        lat = 1; en_seen = 1'b0; sig_bad = 1'b0;
        while (!resp_valid && lat < 60) begin
            if (div_enable) begin
                en_seen = 1'b1;
                if (div_signed_a !== is_s || div_signed_b !== is_s) sig_bad = 1'b1;
            end
            @(negedge clock);
            lat++;
        end
        chk({name, " valid"},  32'(resp_valid), 32'd1);
        chk({name, " data"},   resp_data, exp);
        chk({name, " id"},     32'(resp_id), 32'(id));
        chk({name, " tag"},    32'(resp_tag), 32'(tag));
        chk({name, " div_en"}, 32'(en_seen), 32'(exp_en));
        chk({name, " signed"}, 32'(sig_bad), 32'd0);
        chk({name, " en_resp"}, 32'(div_enable), 32'd0);
        if (exp_lat > 0) chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk({name, " vdrop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int         g, r, cyc, left0, left1;
        logic [5:0] gv, rv;
        logic       bad;

        reset_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst div_enable", 32'(div_enable), 32'd0);
        chk("rst resp_data",  resp_data, 32'd0);
        chk("rst div_a",      div_a, 32'd0);
        chk("rst req_ready",  32'(req_ready), 32'd0);
        reset_n = 1'b1;

        run_op(1'b0, OP_DIVU, 32'd15634654, 32'd21354, 4'd1, 32'd732, -1, 1'b1, "divu");
        run_op(1'b0, OP_REMU, 32'd15634654, 32'd21354, 4'd2, 32'd3526, REUSE ? 1 : -1, !REUSE, "remu");
        run_op(1'b1, OP_DIVU, 32'd100, 32'd0, 4'd3, 32'hFFFF_FFFF, 1, 1'b0, "divu_zero");
        run_op(1'b1, OP_REMU, 32'd100, 32'd0, 4'd4, 32'd100, 1, 1'b0, "remu_zero");
        run_op(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 32'h8000_0000, 1, 1'b0, "div_ovf");
        run_op(1'b1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 32'd0, 1, 1'b0, "rem_ovf");
        run_op(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd7, 32'hFFFF_FFFD, -1, 1'b1, "div_neg");
        run_op(1'b1, OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd8, 32'hFFFF_FFFF, REUSE ? 1 : -1, !REUSE, "rem_neg");
        run_op(1'b0, OP_DIV, 32'd1000, 32'd7, 4'd9, 32'd142, -1, 1'b1, "div_1000_7");
        run_op(1'b1, OP_REM, 32'd1000, 32'd7, 4'd10, 32'd6, REUSE ? 1 : -1, !REUSE, "rem_1000_7");

        // Both requesters valid continuously, three ops each; pointer is at 0 here.
        @(negedge clock);
        resp_ready = 1'b1;
        req_op = 4'b0101; req_a = {32'd200, 32'd100}; req_b = '0; req_tag = 8'h21;
        req_valid = 2'b11;
        left0 = 3; left1 = 3; g = 0; r = 0; cyc = 0; gv = '0; rv = '0;
        while ((g < 6 || r < 6) && cyc < 200) begin
            #1;
            if (resp_valid && r < 6) begin rv = {rv[4:0], resp_id[0]}; r++; end
            if (req_ready[0] && g < 6) begin gv = {gv[4:0], 1'b0}; g++; left0--; end
            else if (req_ready[1] && g < 6) begin gv = {gv[4:0], 1'b1}; g++; left1--; end
            @(negedge clock);
            cyc++;
            if (left0 == 0) req_valid[0] = 1'b0;
            if (left1 == 0) req_valid[1] = 1'b0;
        end
        resp_ready = 1'b0;
        chk("rr grants",    32'(g), 32'd6);
        chk("rr responses", 32'(r), 32'd6);
        chk("rr grant order", 32'(gv), 32'(6'b010101));
        chk("rr resp order",  32'(rv), 32'(6'b010101));

        // Stall in RESP with the other requester waiting.
        @(negedge clock);
        req_op[1:0] = OP_DIVU; req_a[31:0] = 32'd77; req_b[31:0] = 32'd0; req_tag[3:0] = 4'hC;
        req_valid[0] = 1'b1;
        #1;
        chk("stall accept", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            #1;
            if (req_ready !== 2'b00 || resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF ||
                resp_id !== 1'b0 || resp_tag !== 4'hC) bad = 1'b1;
            @(negedge clock);
        end
        chk("stall stable", 32'(bad), 32'd0);
        req_valid[1] = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("stall release", 32'(resp_valid), 32'd0);

        // Reset while the divider is running.
        @(negedge clock);
        req_op[1:0] = OP_DIVU; req_a[31:0] = 32'd1000; req_b[31:0] = 32'd3; req_tag[3:0] = 4'd9;
        req_valid[0] = 1'b1;
        #1;
        chk("busy accept", 32'(req_ready[0]), 32'd1);
        @(negedge clock);
        req_valid[0] = 1'b0;
        #1;
        chk("busy div_en", 32'(div_enable), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        chk("midrst div_en", 32'(div_enable), 32'd0);
        chk("midrst valid",  32'(resp_valid), 32'd0);
        chk("midrst ready",  32'(req_ready), 32'd0);
        chk("midrst div_a",  div_a, 32'd0);
        chk("midrst tag",    32'(resp_tag), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        req_valid[1] = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            #1;
            if (resp_valid || div_enable) bad = 1'b1;
            @(negedge clock);
        end
        chk("midrst no resp", 32'(bad), 32'd0);

        // Previously seen operands must use the divider again after reset.
        run_op(1'b1, OP_DIV, 32'd1000, 32'd7, 4'd12, 32'd142, -1, 1'b1, "post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
